// File: rtl/frame_mon_pkg.sv
// rtl/frame_mon_pkg.sv - shared types and defaults for the frame deviation monitor
package frame_mon_pkg;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    OK    = 2'd1,
    RUN   = 2'd2,
    ALARM = 2'd3
  } mon_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_RUN_LEN = 3;
  localparam int DEF_RUN_W   = $clog2(DEF_RUN_LEN + 1);

  // Run counter must hold the value RUN_LEN itself.
  function automatic int run_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/frame_deviation_monitor_sat_counter.sv
// rtl/frame_deviation_monitor_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/frame_deviation_monitor.sv
// rtl/frame_deviation_monitor.sv - per-frame statistics, run-length alarm and alarm event port
module frame_deviation_monitor
  import frame_mon_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic [WIDTH-1:0] avg_in,
  input  logic [WIDTH-1:0] diff_in,
  input  logic [WIDTH-1:0] thresh,
  input  logic             clear,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] over_cnt,
  output logic [WIDTH-1:0] peak_diff,
  output logic             alarm,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_avg,
  output logic [WIDTH-1:0] evt_diff,
  output logic [CNT_W-1:0] evt_frame,
  output logic             evt_ovf
);

  localparam int RUN_W = run_width(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(RUN_LEN);

  mon_state_t       state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic             exceed, accept, enter_alarm, xfer;
  logic [CNT_W-1:0] frame_nxt;

  always_ff @(posedge clk) begin
    if (!rst) state <= SKIP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clear) begin
      state_nxt = SKIP;
      run_nxt   = '0;
    end else if (done_in) begin
      case (state)
        SKIP: state_nxt = OK;
        OK: if (exceed) begin
          run_nxt   = RUN_ONE;
          state_nxt = (RUN_LEN == 1) ? ALARM : RUN;
        end
        RUN: if (exceed) begin
          run_nxt = run + RUN_ONE;
          if (run + RUN_ONE == RUN_TGT) state_nxt = ALARM;
        end else begin
          state_nxt = OK;
          run_nxt   = '0;
        end
        ALARM: if (!exceed) begin
          state_nxt = OK;
          run_nxt   = '0;
        end
        default: state_nxt = SKIP;
      endcase
    end
  end

  always_comb begin
    exceed      = diff_in > thresh;
    accept      = done_in && !clear && (state != SKIP);
    enter_alarm = accept && exceed && (state_nxt == ALARM) && (state != ALARM);
    xfer        = evt_valid && evt_ready;
    frame_nxt   = (frame_cnt == {CNT_W{1'b1}}) ? frame_cnt : frame_cnt + 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk(clk), .rst(rst), .inc(accept), .clr(clear), .count(frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_over_cnt (
    .clk(clk), .rst(rst), .inc(accept && exceed), .clr(clear), .count(over_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      run       <= '0;
      peak_diff <= '0;
      alarm     <= 1'b0;
      evt_valid <= 1'b0;
      evt_avg   <= '0;
      evt_diff  <= '0;
      evt_frame <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      run <= run_nxt;
      if (accept && (diff_in > peak_diff)) peak_diff <= diff_in;
      // A transfer in the entry cycle frees the slot, so the new event takes it.
      if (enter_alarm) begin
        alarm <= 1'b1;
        if (!evt_valid || xfer) begin
          evt_valid <= 1'b1;
          evt_avg   <= avg_in;
          evt_diff  <= diff_in;
          evt_frame <= frame_nxt;
        end else begin
          evt_ovf <= 1'b1;
        end
      end else if (xfer) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_deviation_monitor.md
# frame_deviation_monitor

Downstream consumer of the serial-averager stage. Samples the per-frame average and absolute deviation whenever the averager signals completion, keeps saturating frame and outlier statistics plus a peak deviation, and raises a sticky alarm after a run of consecutive out-of-threshold frames. Each alarm entry is reported as one event on a valid/ready port toward the system status logic.

## Interface
- WIDTH, 8, width of sample, average, deviation and threshold
- CNT_W, 8, width of the frame and outlier counters
- RUN_LEN, 3, consecutive exceeding frames needed to alarm (≥1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- done_in  in  1  upstream completion strobe, high one cycle per frame
- avg_in  in  WIDTH  upstream frame average, valid when done_in=1
- diff_in  in  WIDTH  upstream |last sample − average|, valid when done_in=1
- thresh  in  WIDTH  deviation threshold, quasi-static
- clear  in  1  synchronous clear of statistics, alarm and event
- frame_cnt  out  CNT_W  accepted frames, saturating
- over_cnt  out  CNT_W  accepted frames with diff_in > thresh, saturating
- peak_diff  out  WIDTH  largest accepted diff_in
- alarm  out  1  sticky alarm
- evt_valid  out  1  alarm event pending
- evt_ready  in  1  consumer accepts event
- evt_avg, evt_diff  out  WIDTH each  avg/diff of the alarm-triggering frame
- evt_frame  out  CNT_W  frame_cnt value (post-increment) of that frame
- evt_ovf  out  1  sticky: an alarm entry occurred while an event was pending

## Operation
- Accept: done_in=1 in any state except SKIP. The first done_in after reset or clear is discarded: the upstream strobe fires before its first frame completes.
- Exceed: diff_in > thresh (strict, unsigned). diff_in == thresh does not exceed.
- FSM states: SKIP, OK, RUN, ALARM.
  - SKIP → OK on the first done_in, with no other effect.
  - OK: exceeding frame → run=1. If RUN_LEN=1, go to ALARM; otherwise go to RUN.
  - RUN: exceeding frame → run+1. When run reaches RUN_LEN, go to ALARM. Non-exceeding frame → OK, run=0.
  - ALARM: exceeding frame → stay, with no new event. Non-exceeding frame → OK, run=0.
- On ALARM entry:
  - set alarm.
  - if evt_valid=0: load evt_* and set evt_valid.
  - if evt_valid=1: keep the held event and set evt_ovf.
- Accepted frame effects:
  - frame_cnt+1.
  - over_cnt+1 if exceeding.
  - peak_diff = max(peak_diff, diff_in).
  - Counters hold at 2^CNT_W−1.
- Event handshake:
  - evt_* stable while evt_valid=1.
  - Transfer occurs when evt_valid & evt_ready; evt_valid drops the next cycle.
  - Entry and transfer in the same cycle: the new event is loaded, evt_valid stays 1, and evt_ovf is not set.
- clear: all outputs go to 0, FSM → SKIP, run=0. If clear and done_in are high together, clear wins and the frame is discarded.

## Timing
- Reset (rst=0 at edge): FSM=SKIP, run=0. Every output is 0: frame_cnt, over_cnt, peak_diff, alarm, evt_valid, evt_avg, evt_diff, evt_frame, evt_ovf.
- Latency: inputs sampled at edge t; all statistics, alarm and evt_* are visible after edge t, one cycle.
- done_in is a level that is examined every cycle, so back-to-back done_in cycles are two frames.
- Reset mid-run or mid-handshake: a pending event is dropped without transfer.
- Frames keep being accepted while evt_valid waits; accepting frames never depends on evt_ready.

## Structure
- Package frame_mon_pkg:
  - FSM state enum (SKIP, OK, RUN, ALARM).
  - default WIDTH/CNT_W/RUN_LEN constants.
  - run counter width, $clog2(RUN_LEN+1).
- One sub-module, sat_counter (parameter W; inputs inc, clr; output saturating count), instantiated for frame_cnt and over_cnt.
- Everything else stays inline in a single always block for the FSM and datapath.

## Test plan
- Reset, then done_in pulses with diff_in = 5,5,5, thresh = 10:
  - first pulse ignored.
  - then frame_cnt=2, over_cnt=0, peak_diff=5, alarm=0.
- thresh=10, diff_in = 11,11,11 (after the skip pulse), RUN_LEN=3:
  - alarm and evt_valid rise the cycle after the third frame.
  - evt_diff=11, evt_frame=3.
- Runs 11,11,9,11,11 and diff_in==thresh=10 repeated:
  - neither case alarms.
  - over_cnt counts only the 11s.
- Hold evt_ready=0, then trigger alarm, a clean frame, and a second alarm run:
  - first event held unchanged, evt_ovf=1.
  - after evt_ready=1 for one cycle, evt_valid=0.
- CNT_W=4, 20 accepted frames: frame_cnt stays at 15.
- Corner cases:
  - clear together with done_in: frame discarded, FSM back to SKIP.
  - rst=0 while evt_valid=1: all outputs go to 0 the next cycle.
